// File: rtl/temp_bcd_pkg.sv
// -----------------------------------------------------------------------------
// temp_bcd_pkg
// Shared constants for the binary-to-BCD temperature converter:
//   - FSM state encodings (IDLE, SHIFT, DONE)
//   - iteration count of the double-dabble loop
//   - number of BCD scratch digits and the add-3 threshold
// -----------------------------------------------------------------------------
package temp_bcd_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One iteration per bit of the 8-bit operand
    localparam int         ITERATIONS     = 8;
    localparam logic [3:0] LAST_ITER      = 4'(ITERATIONS - 1);

    // Scratch holds hundreds, tens and ones
    localparam int         BCD_DIGITS     = 3;
    localparam int         BCD_W          = 4 * BCD_DIGITS;

    // A digit at or above this value overflows past 9 once doubled
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

endpackage : temp_bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Purely combinational double-dabble digit correction: adds 3 to a BCD digit
// that is >= 5 so that the following left shift carries correctly into the
// next decimal digit.
// Ports:
//   i_digit  in   4  BCD digit before correction
//   o_digit  out  4  corrected BCD digit
// -----------------------------------------------------------------------------
module bcd_add3
    import temp_bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESHOLD) ? i_digit + 4'd3 : i_digit;

endmodule : bcd_add3

// File: rtl/temp_bcd_converter.sv
// -----------------------------------------------------------------------------
// temp_bcd_converter
// Converts an 8-bit unsigned temperature into two packed BCD digits for the
// 7-segment display stage using a sequential double-dabble (one bit per clock).
// Values of 100 or more saturate to SAT_BCD and raise overRange.
// Ports:
//   sysCLK       in   1  system clock, rising edge
//   resetN       in   1  synchronous active-low reset
//   tempBinary   in   8  binary temperature, sampled when a start is accepted
//   start        in   1  conversion request, honoured only in IDLE
//   clear        in   1  synchronous clear of held result, aborts conversion
//   busy         out  1  conversion in progress (SHIFT or DONE)
//   done         out  1  one-cycle pulse: new result on decimalTemp
//   overRange    out  1  held result was saturated
//   decimalTemp  out  8  packed BCD {tens, ones}
//   display      out  1  display enable, high once a valid result is held
// Latency: start sampled at edge k -> done/decimalTemp valid after edge k+9.
// -----------------------------------------------------------------------------
module temp_bcd_converter
    import temp_bcd_pkg::*;
#(
    parameter logic [7:0] SAT_BCD = 8'h99
) (
    input  logic       sysCLK,
    input  logic       resetN,
    input  logic [7:0] tempBinary,
    input  logic       start,
    input  logic       clear,
    output logic       busy,
    output logic       done,
    output logic       overRange,
    output logic [7:0] decimalTemp,
    output logic       display
);

    logic [1:0]       r_state;
    logic [7:0]       r_operand;
    logic [BCD_W-1:0] r_scratch;
    logic [3:0]       r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_over;
    logic [7:0]       r_decimal;
    logic             r_display;

    logic [BCD_W-1:0] w_scratch_adj;

    // One add-3 corrector per scratch digit (ones, tens, hundreds)
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_scratch_adj[4*g +: 4])
        );
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would chain the shift within one edge.
    always_ff @(posedge sysCLK) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_operand <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_over    <= 1'b0;
            r_decimal <= '0;
            r_display <= 1'b0;
        end else if (clear) begin
            // Clear aborts any conversion and discards a simultaneous start
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_over    <= 1'b0;
            r_decimal <= '0;
            r_display <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_operand <= tempBinary;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_state   <= ST_SHIFT;
                        r_busy    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Correct digits first, then shift {scratch, operand} left
                    {r_scratch, r_operand} <= {w_scratch_adj[BCD_W-2:0], r_operand, 1'b0};
                    r_count <= r_count + 4'd1;
                    if (r_count == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Nonzero hundreds digit cannot be shown on two digits
                    if (r_scratch[11:8] != 4'd0) begin
                        r_decimal <= SAT_BCD;
                        r_over    <= 1'b1;
                    end else begin
                        r_decimal <= r_scratch[7:0];
                        r_over    <= 1'b0;
                    end
                    r_display <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign overRange   = r_over;
    assign decimalTemp = r_decimal;
    assign display     = r_display;

endmodule : temp_bcd_converter

// File: doc/temp_bcd_converter.md
TEMP_BCD_CONVERTER -- requirements
Module: temp_bcd_converter

Interface
REQ-001 Parameter SAT_BCD, default 8'h99: packed-BCD value driven when the input exceeds two decimal digits.
REQ-002 sysCLK  input  1  single system clock; all state updates on rising edge.
REQ-003 resetN  input  1  reset, synchronous and active-low.
REQ-004 tempBinary  input  8  unsigned binary temperature, 0..255.
REQ-005 start  input  1  conversion request, sampled only in IDLE.
REQ-006 clear  input  1  synchronous clear of held result and display enable.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-008 done  output  1  one-cycle pulse marking a new result on decimalTemp.
REQ-009 overRange  output  1  high when the held result was saturated.
REQ-010 decimalTemp  output  8  packed BCD result: [7:4] tens digit, [3:0] ones digit; feeds the 7-segment display stage.
REQ-011 display  output  1  display enable for the 7-segment stage; high once a valid result is held.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 and clear=0 at edge k, the block SHALL capture tempBinary into an 8-bit shift register, zero a 12-bit BCD scratch (hundreds/tens/ones), zero a 4-bit iteration counter, and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL perform one double-dabble iteration: add 3 to every scratch digit that is >=5, then left-shift {scratch, operand} by one bit.
REQ-015 After the 8th iteration (edge k+8), the FSM SHALL enter DONE.
REQ-016 At edge k+9 (DONE), the block SHALL load decimalTemp, set display=1, pulse done high for exactly the following cycle, and return to IDLE.
REQ-017 Latency: start sampled at edge k gives decimalTemp valid and done=1 after edge k+9. A new start is accepted no earlier than edge k+10.
REQ-018 If the hundreds digit is nonzero (input >=100), the block SHALL load decimalTemp=SAT_BCD and set overRange=1. Otherwise it SHALL load {tens, ones} and set overRange=0.
REQ-019 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 tempBinary changes after edge k SHALL NOT affect the conversion in progress.
REQ-021 decimalTemp, overRange and display SHALL hold their last values between conversions.
REQ-022 clear=1 in any state SHALL, at that edge, set decimalTemp=8'h00, overRange=0, display=0 and done=0, and force IDLE (aborting any conversion).
REQ-023 clear SHALL have priority over a simultaneous start; that start is discarded.
REQ-024 busy SHALL be a registered decode of state: high in SHIFT and DONE, low in IDLE.

Reset
REQ-025 resetN=0 at a rising edge SHALL force IDLE, decimalTemp=8'h00, overRange=0, display=0, done=0, busy=0, counter=0 and scratch=0.
REQ-026 Reset mid-conversion SHALL discard the partial result; no done pulse SHALL follow.
REQ-027 Reset SHALL take priority over clear and start.

Structure
REQ-028 A shared package temp_bcd_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE), ITERATIONS=8, BCD_DIGITS=3 and the add-3 threshold constant 5.
REQ-029 A single combinational sub-module, bcd_add3, SHALL implement the per-digit conditional add-3 and be instantiated once per scratch digit.
REQ-030 All registers SHALL reside in temp_bcd_converter; there is no second clock domain.

Verification
REQ-031 tempBinary=0, pulse start -> after 10 edges decimalTemp=8'h00, done pulse 1 cycle, display=1, overRange=0.
REQ-032 tempBinary=23, then 45, then 99, back-to-back starts at the earliest acceptance -> decimalTemp=8'h23, 8'h45, 8'h99 in turn, each with one done pulse.
REQ-033 tempBinary=100, then 255 -> decimalTemp=8'h99 and overRange=1 both times. Then tempBinary=67 -> 8'h67 and overRange=0.
REQ-034 start re-pulsed at cycles k+3 and k+9 during conversion of 89 -> exactly one done pulse; result 8'h89; busy stays high through k+9.
REQ-035 resetN=0 at edge k+4 during conversion of 56 -> all outputs 0, state IDLE, no done pulse; the next start converts correctly.
REQ-036 clear and start asserted together after a held 8'h42 -> decimalTemp=8'h00, display=0, busy stays 0.
